// File: rtl/rv32i_pkg.sv
// rv32i_pkg: definitions shared by the RV32I fetch logic.
//   XLEN          - architectural register / address width
//   PC_STEP       - byte increment between sequential instruction words
//   fetch_state_e - fetch sequencer states (IDLE, FETCH, FAULT)
//   is_aligned    - true when a byte address is 32-bit word aligned
package rv32i_pkg;

    localparam int          XLEN    = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    function automatic logic is_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular queue of {pc, instr} words.
//   clk, reset     - core clock, asynchronous active-low reset
//   push/push_data - enqueue; accepted when not full, or when full with a pop
//   pop            - dequeue the head (ignored when empty)
//   flush          - drop all entries; the head register keeps its last value
//   count          - number of valid entries
//   head           - registered copy of the oldest entry; holds when empty
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d, remain;
    logic [WIDTH-1:0] head_q, head_d;
    logic             pop_eff, push_eff;

    always_comb begin
        pop_eff  = pop && (count_q != '0);
        push_eff = push && !flush && ((count_q != FULL_CNT) || pop_eff);
        remain   = count_q - (AW+1)'(pop_eff);
        rd_ptr_d = rd_ptr_q + AW'(pop_eff);
        count_d  = remain + (AW+1)'(push_eff);
        // The head register is loaded with whatever becomes oldest next cycle:
        // a surviving stored entry, or the word being pushed into an empty queue.
        head_d   = head_q;
        if (remain != '0) begin
            head_d = mem_q[rd_ptr_d];
        end else if (push_eff) begin
            head_d = push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push_eff);
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign count = count_q;
    assign head  = head_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction fetch sequencer between a combinational-read
// instruction memory and the decode stage.
//   clk, reset         - core clock, asynchronous active-low reset
//   start              - level, enables fetching
//   imem_addr          - byte address to instruction memory (the pc)
//   imem_instr         - instruction returned for imem_addr
//   redirect_valid/pc  - one-cycle redirect request and its target
//   out_valid/ready    - handshake to decode
//   out_instr/out_pc   - head of the fetch queue
//   fault              - misaligned redirect trapped
// Build option: MISALIGN_CHECK_EN enables the FAULT state for misaligned
// redirect targets; without it the low two target bits are dropped and fault is 0.
//
// state    | meaning
// ST_IDLE  | not fetching, queue may still drain
// ST_FETCH | pushing {pc, instr} every cycle the queue can take it
// ST_FAULT | misaligned redirect trapped, waiting for an aligned redirect
module imem_fetch_ctrl
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            fault
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e      state_q;
    logic [XLEN-1:0]   pc_q;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] head;
    logic              full, pop, push;

    assign full      = (count == CW'(FIFO_DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full queue still accepts a push.
    assign push      = (state_q == ST_FETCH) & start & ~redirect_valid & (~full | pop);

`ifdef MISALIGN_CHECK_EN
    logic fault_q;
    logic redirect_bad;
    assign redirect_bad = redirect_valid & ~is_aligned(redirect_pc);
    assign fault        = fault_q;
`else
    assign fault        = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
`ifdef MISALIGN_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else if (redirect_valid) begin
`ifdef MISALIGN_CHECK_EN
            if (redirect_bad) begin
                state_q <= ST_FAULT;
                fault_q <= 1'b1;
            end else begin
                pc_q    <= {redirect_pc[XLEN-1:2], 2'b00};
                fault_q <= 1'b0;
                if (state_q == ST_FAULT) begin
                    state_q <= start ? ST_FETCH : ST_IDLE;
                end
            end
`else
            pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (!start) begin
                        state_q <= ST_IDLE;
                    end else if (push) begin
                        pc_q <= pc_q + PC_STEP;
                    end
                end
                default: state_q <= state_q;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2*XLEN)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({pc_q, imem_instr}),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head)
    );

    assign imem_addr = pc_q;
    assign out_pc    = head[2*XLEN-1:XLEN];
    assign out_instr = head[XLEN-1:0];

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl (RESET_PC = 0, FIFO_DEPTH = 4).
// The memory model returns word index i at byte address 4*i.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, redirect_valid, out_ready;
    logic [31:0] imem_addr, imem_instr, redirect_pc, out_instr, out_pc;
    logic        out_valid, fault;

    int n_total = 0;
    int n_pass  = 0;
    int lat;
    logic [31:0] base;

    always #5 clk = ~clk;

    assign imem_instr = imem_addr >> 2;

    imem_fetch_ctrl #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fault          (fault)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (3) step();
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_pc",    out_pc,    32'h0);
        check("rst_fault",     32'(fault), 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);

        // Sequential stream with decode always ready
        reset = 1'b1; start = 1'b1; out_ready = 1'b1;
        lat = 0;
        while (!out_valid && lat < 8) begin
            step();
            lat++;
        end
        check("t1_first_valid_edges", 32'(lat), 32'd2);
        for (int k = 0; k < 6; k++) begin
            check("t1_valid", 32'(out_valid), 32'h1);
            check("t1_pc",    out_pc,    32'(4*k));
            check("t1_instr", out_instr, 32'(k));
            step();
        end

        // Asynchronous reset mid-stream
        check("t5_pre_valid", 32'(out_valid), 32'h1);
        #1 reset = 1'b0;
        #1;
        check("t5_async_valid", 32'(out_valid), 32'h0);
        check("t5_async_pc",    out_pc,    32'h0);
        check("t5_async_addr",  imem_addr, 32'h0);
        reset = 1'b1; start = 1'b1; out_ready = 1'b0;

        // Backpressure: queue fills to depth, head held
        step();
        check("t2_idle_valid", 32'(out_valid), 32'h0);
        repeat (10) step();
        check("t2_full_addr",  imem_addr, 32'h10);
        check("t2_full_valid", 32'(out_valid), 32'h1);
        check("t2_hold_pc",    out_pc,    32'h0);
        check("t2_hold_instr", out_instr, 32'h0);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("t2_drain_valid", 32'(out_valid), 32'h1);
            check("t2_drain_pc",    out_pc, 32'(4*k));
            step();
        end
        check("t2_full_popush_addr", imem_addr, 32'h30);

        // Redirect while full
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        check("t3_flush_valid", 32'(out_valid), 32'h0);
        check("t3_addr",        imem_addr, 32'h100);
        step();
        check("t3_tgt_valid", 32'(out_valid), 32'h1);
        check("t3_tgt_pc",    out_pc,    32'h100);
        check("t3_tgt_instr", out_instr, 32'h40);
        step();
        check("t3_next_pc",    out_pc,    32'h104);
        check("t3_next_instr", out_instr, 32'h41);

        // Wrap at top of address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("t4_flush_valid", 32'(out_valid), 32'h0);
        step();
        check("t4_top_pc",    out_pc,    32'hFFFF_FFFC);
        check("t4_top_instr", out_instr, 32'h3FFF_FFFF);
        step();
        check("t4_wrap_pc",    out_pc,    32'h0);
        check("t4_wrap_instr", out_instr, 32'h0);
        check("t4_wrap_addr",  imem_addr, 32'h4);

        // Misaligned redirect
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        step();
        redirect_valid = 1'b0;
`ifdef MISALIGN_CHECK_EN
        check("t6_fault_set",  32'(fault), 32'h1);
        check("t6_fault_valid", 32'(out_valid), 32'h0);
        repeat (3) step();
        check("t6_fault_nopush", 32'(out_valid), 32'h0);
        check("t6_fault_held",   32'(fault), 32'h1);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        check("t6_fault_clear", 32'(fault), 32'h0);
        base = 32'h200;
`else
        check("t6_fault_zero", 32'(fault), 32'h0);
        base = 32'h100;
`endif
        check("t6_addr",  imem_addr, base);
        check("t6_valid", 32'(out_valid), 32'h0);
        step();
        check("t6_tgt_valid", 32'(out_valid), 32'h1);
        check("t6_tgt_pc",    out_pc, base);

        // start low: back to IDLE, pc holds, queue drains, outputs hold
        start = 1'b0;
        step();
        check("idle_drained", 32'(out_valid), 32'h0);
        check("idle_hold_pc", out_pc, base);
        check("idle_addr",    imem_addr, base + 32'h4);
        repeat (3) step();
        check("idle_addr_held", imem_addr, base + 32'h4);

        // Redirect while idle: pc updates, nothing fetched
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        step();
        redirect_valid = 1'b0;
        check("idle_redir_addr", imem_addr, 32'h300);
        step();
        check("idle_redir_valid", 32'(out_valid), 32'h0);
        start = 1'b1;
        step();
        step();
        check("idle_resume_valid", 32'(out_valid), 32'h1);
        check("idle_resume_pc",    out_pc, 32'h300);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
